// File: rtl/vga_timing_generator_if.sv
// Raster timing bundle between vga_timing_generator (master) and the pixel generator (slave).
interface vga_timing_if;
    logic       pixel_clk;
    logic [9:0] cycle;
    logic [8:0] scanline;
    logic       vga_blank;
    logic       hsync;
    logic       vsync;
    logic       frame_start;
    logic       irq;
    logic       irq_ack;

    modport master (
        output pixel_clk, cycle, scanline, vga_blank, hsync, vsync, frame_start, irq,
        input  irq_ack
    );

    modport slave (
        input  pixel_clk, cycle, scanline, vga_blank, hsync, vsync, frame_start, irq,
        output irq_ack
    );
endinterface

// File: rtl/vga_timing_generator.sv
// Free-running 640x480@60 raster timing source with a CLK_DIV pixel strobe.
// Define VGA_VBLANK_IRQ_EN to build the vertical-blank interrupt (irq/irq_ack).
module vga_timing_generator #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic          clk,
    input  logic          rst,
    vga_timing_if.master  bus
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE      = DIV_W'(1);
    localparam logic [9:0]       H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_VIS        = 10'(H_VISIBLE);
    localparam logic [9:0]       V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0]       H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0]       H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]       V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]       V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;
    logic [9:0]       h;
    logic [9:0]       h_next;
    logic [9:0]       v;
    logic [9:0]       v_next;
    logic             advance;
    logic             line_end;
    logic             frame_end;

    // Outputs are derived from the next counter state so they all flip together on the advancing edge.
    always_comb begin
        advance   = (div == DIV_LAST);
        line_end  = advance && (h == H_LAST);
        frame_end = line_end && (v == V_LAST);
        div_next  = advance ? '0 : div + DIV_ONE;
        h_next    = h;
        v_next    = v;
        if (advance) begin
            h_next = (h == H_LAST) ? 10'd0 : h + 10'd1;
        end
        if (line_end) begin
            v_next = (v == V_LAST) ? 10'd0 : v + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div             <= '0;
            h               <= '0;
            v               <= '0;
            bus.pixel_clk   <= 1'b0;
            bus.cycle       <= '0;
            bus.scanline    <= '0;
            bus.vga_blank   <= 1'b0;
            bus.hsync       <= 1'b1;
            bus.vsync       <= 1'b1;
            bus.frame_start <= 1'b0;
        end else begin
            div             <= div_next;
            h               <= h_next;
            v               <= v_next;
            bus.pixel_clk   <= (div_next == DIV_LAST);
            bus.cycle       <= h_next;
            bus.scanline    <= (v_next < V_VIS) ? v_next[8:0] : 9'd0;
            bus.vga_blank   <= (h_next >= H_VIS) || (v_next >= V_VIS);
            bus.hsync       <= !((h_next >= H_SYNC_FIRST) && (h_next <= H_SYNC_LAST));
            bus.vsync       <= !((v_next >= V_SYNC_FIRST) && (v_next <= V_SYNC_LAST));
            bus.frame_start <= frame_end;
        end
    end

`ifdef VGA_VBLANK_IRQ_EN
    localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);

    logic irq_set;

    assign irq_set = line_end && (v == V_VIS_LAST);

    // A set coinciding with an ack wins so a fresh vblank is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.irq <= 1'b0;
        end else if (irq_set) begin
            bus.irq <= 1'b1;
        end else if (bus.irq_ack) begin
            bus.irq <= 1'b0;
        end
    end
`else
    logic unused_irq_ack;

    assign unused_irq_ack = bus.irq_ack;
    assign bus.irq        = 1'b0;
`endif

endmodule
